// File: rtl/mainfsm_ext_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mainfsm_ext_pkg
// Description : Shared state encoding and datapath mux codes for the
//               extended multi-cycle ARM control FSM.
// Revision    : 1.0 - initial release
// ============================================================================
package mainfsm_ext_pkg;

    // Controller states; StateOut exposes this encoding for debug.
    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        EXECUTER = 4'd2,
        EXECUTEI = 4'd3,
        ALUWB    = 4'd4,
        MEMADR   = 4'd5,
        MEMRD    = 4'd6,
        MEMWB    = 4'd7,
        MEMWR    = 4'd8,
        BRLINK   = 4'd9,
        BRANCH   = 4'd10,
        MULEXEC  = 4'd11,
        MULWB    = 4'd12,
        UNDEF    = 4'd13
    } state_t;

    // ALU operand B select
    localparam logic [1:0] c_SRCB_REG  = 2'b00;
    localparam logic [1:0] c_SRCB_IMM  = 2'b01;
    localparam logic [1:0] c_SRCB_FOUR = 2'b10;
    localparam logic [1:0] c_SRCB_ZERO = 2'b11;

    // Writeback result select
    localparam logic [1:0] c_RES_ALUOUT = 2'b00;
    localparam logic [1:0] c_RES_DATA   = 2'b01;
    localparam logic [1:0] c_RES_ALURES = 2'b10;
    localparam logic [1:0] c_RES_MUL    = 2'b11;

endpackage
`default_nettype wire

// File: rtl/mainfsm_ext_if.sv
`default_nettype none
// ============================================================================
// Module      : mainfsm_ext_if
// Description : Decoder-to-controller inputs and controller-to-datapath
//               control bundle. master = controller, slave = datapath side.
// Revision    : 1.0 - initial release
// ============================================================================
interface mainfsm_ext_if;
    logic [1:0] Op;
    logic [5:0] Funct;
    logic       IsMul;
    logic       Link;
    logic       MemReady;

    logic       IRWrite;
    logic       AdrSrc;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ResultSrc;
    logic       NextPC;
    logic       RegW;
    logic       LinkSel;
    logic       MemW;
    logic       MemReq;
    logic       Branch;
    logic       ALUOp;
    logic       MulStart;
    logic       Undef;
    logic [3:0] StateOut;

    modport master (
        input  Op, Funct, IsMul, Link, MemReady,
        output IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW,
               LinkSel, MemW, MemReq, Branch, ALUOp, MulStart, Undef, StateOut
    );

    modport slave (
        output Op, Funct, IsMul, Link, MemReady,
        input  IRWrite, AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, NextPC, RegW,
               LinkSel, MemW, MemReq, Branch, ALUOp, MulStart, Undef, StateOut
    );
endinterface
`default_nettype wire

// File: rtl/mul_wait_counter.sv
`default_nettype none
// ============================================================================
// Module      : mul_wait_counter
// Description : Loadable down-counter timing the multiply execute phase.
//               Saturates at zero; o_zero flags the final MULEXEC cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_wait_counter #(
    parameter int WIDTH = 3
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             i_load,
    input  wire logic [WIDTH-1:0] i_load_val,
    input  wire logic             i_dec,
    output logic      [WIDTH-1:0] o_count,
    output logic                  o_zero
);

    logic [WIDTH-1:0] r_count;

    // Load on MULEXEC entry, otherwise count down to zero and hold.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign o_count = r_count;
    assign o_zero  = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/mainfsm_ext.sv
`default_nettype none
// ============================================================================
// Module      : mainfsm_ext
// Description : Multi-cycle ARM main control FSM with memory wait states,
//               iterative multiply, branch-with-link and undefined trap.
// Revision    : 1.0 - initial release
// ============================================================================
module mainfsm_ext
    import mainfsm_ext_pkg::*;
#(
    parameter bit MUL_EN      = 1'b1,
    parameter int MUL_CYCLES  = 4,
    parameter bit MEM_WAIT_EN = 1'b1
) (
    input  wire logic          clk,
    input  wire logic          reset,
    mainfsm_ext_if.master      bus
);

    localparam int c_CNT_W = $clog2(MUL_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_MUL_LOAD = c_CNT_W'(MUL_CYCLES - 1);

    state_t               r_state;
    state_t               w_next;
    logic                 w_rdy;
    logic                 w_cnt_load;
    logic                 w_cnt_dec;
    logic                 w_cnt_zero;
    logic [c_CNT_W-1:0]   w_cnt;

    logic       w_irwrite, w_adrsrc, w_alusrca, w_nextpc, w_regw, w_linksel;
    logic       w_memw, w_memreq, w_branch, w_aluop, w_mulstart, w_undef;
    logic [1:0] w_alusrcb, w_resultsrc;
    logic       w_unused_funct;

    // Memory completion qualifier; without wait support every access is one cycle.
    generate
        if (MEM_WAIT_EN) begin : g_mem_wait
            assign w_rdy = bus.MemReady;
        end else begin : g_no_mem_wait
            assign w_rdy = 1'b1;
        end
    endgenerate

    // Counter is loaded on the DECODE->MULEXEC transition so the first
    // MULEXEC cycle sees MUL_CYCLES-1 and the last sees zero.
    assign w_cnt_load = (r_state == DECODE) && (w_next == MULEXEC);
    assign w_cnt_dec  = (r_state == MULEXEC);

    mul_wait_counter #(
        .WIDTH (c_CNT_W)
    ) u_mul_cnt (
        .clk        (clk),
        .reset      (reset),
        .i_load     (w_cnt_load),
        .i_load_val (c_MUL_LOAD),
        .i_dec      (w_cnt_dec),
        .o_count    (w_cnt),
        .o_zero     (w_cnt_zero)
    );

    // State register; reset restarts at FETCH, abandoning any pending access.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and Moore control decode (FETCH strobes qualified by rdy).
    always_comb begin
        w_next      = FETCH;
        w_irwrite   = 1'b0;
        w_adrsrc    = 1'b0;
        w_alusrca   = 1'b0;
        w_alusrcb   = c_SRCB_REG;
        w_resultsrc = c_RES_ALUOUT;
        w_nextpc    = 1'b0;
        w_regw      = 1'b0;
        w_linksel   = 1'b0;
        w_memw      = 1'b0;
        w_memreq    = 1'b0;
        w_branch    = 1'b0;
        w_aluop     = 1'b0;
        w_mulstart  = 1'b0;
        w_undef     = 1'b0;
        case (r_state)
            FETCH: begin
                w_memreq    = 1'b1;
                w_alusrca   = 1'b1;
                w_alusrcb   = c_SRCB_FOUR;
                w_resultsrc = c_RES_ALURES;
                w_irwrite   = w_rdy;
                w_nextpc    = w_rdy;
                w_next      = w_rdy ? DECODE : FETCH;
            end
            DECODE: begin
                w_alusrca   = 1'b1;
                w_alusrcb   = c_SRCB_FOUR;
                w_resultsrc = c_RES_ALURES;
                if ((bus.Op == 2'b00) && bus.IsMul) begin
                    w_next = MUL_EN ? MULEXEC : UNDEF;
                end else begin
                    case (bus.Op)
                        2'b00:   w_next = bus.Funct[5] ? EXECUTEI : EXECUTER;
                        2'b01:   w_next = MEMADR;
                        2'b10:   w_next = bus.Link ? BRLINK : BRANCH;
                        default: w_next = UNDEF;
                    endcase
                end
            end
            EXECUTER: begin
                w_aluop   = 1'b1;
                w_alusrcb = c_SRCB_REG;
                w_next    = ALUWB;
            end
            EXECUTEI: begin
                w_aluop   = 1'b1;
                w_alusrcb = c_SRCB_IMM;
                w_next    = ALUWB;
            end
            ALUWB: begin
                w_regw      = 1'b1;
                w_resultsrc = c_RES_ALUOUT;
                w_next      = FETCH;
            end
            MEMADR: begin
                w_alusrcb = c_SRCB_IMM;
                w_next    = bus.Funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                w_memreq = 1'b1;
                w_adrsrc = 1'b1;
                w_next   = w_rdy ? MEMWB : MEMRD;
            end
            MEMWB: begin
                w_regw      = 1'b1;
                w_resultsrc = c_RES_DATA;
                w_next      = FETCH;
            end
            MEMWR: begin
                w_memreq = 1'b1;
                w_memw   = 1'b1;
                w_adrsrc = 1'b1;
                w_next   = w_rdy ? FETCH : MEMWR;
            end
            BRLINK: begin
                w_alusrca   = 1'b1;
                w_alusrcb   = c_SRCB_ZERO;
                w_resultsrc = c_RES_ALURES;
                w_regw      = 1'b1;
                w_linksel   = 1'b1;
                w_next      = BRANCH;
            end
            BRANCH: begin
                w_branch    = 1'b1;
                w_alusrca   = 1'b0;
                w_alusrcb   = c_SRCB_IMM;
                w_resultsrc = c_RES_ALURES;
                w_next      = FETCH;
            end
            MULEXEC: begin
                w_mulstart = (w_cnt == c_MUL_LOAD);
                w_next     = w_cnt_zero ? MULWB : MULEXEC;
            end
            MULWB: begin
                w_regw      = 1'b1;
                w_resultsrc = c_RES_MUL;
                w_next      = FETCH;
            end
            UNDEF: begin
                w_undef = 1'b1;
                w_next  = FETCH;
            end
            default: begin
                w_next = FETCH;
            end
        endcase
    end

    // Enables are held low while reset is asserted; muxes show FETCH values.
    assign bus.IRWrite   = w_irwrite  & reset;
    assign bus.NextPC    = w_nextpc   & reset;
    assign bus.RegW      = w_regw     & reset;
    assign bus.MemW      = w_memw     & reset;
    assign bus.MemReq    = w_memreq   & reset;
    assign bus.Branch    = w_branch   & reset;
    assign bus.MulStart  = w_mulstart & reset;
    assign bus.Undef     = w_undef    & reset;
    assign bus.AdrSrc    = w_adrsrc;
    assign bus.ALUSrcA   = w_alusrca;
    assign bus.ALUSrcB   = w_alusrcb;
    assign bus.ResultSrc = w_resultsrc;
    assign bus.LinkSel   = w_linksel;
    assign bus.ALUOp     = w_aluop;
    assign bus.StateOut  = r_state;

    // Funct[4:1] carry ALU function bits consumed by the ALU decoder, not here.
    assign w_unused_funct = ^bus.Funct[4:1];

endmodule
`default_nettype wire

// File: tb/tb_mainfsm_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_mainfsm_ext
// Description : Scoreboard bench for mainfsm_ext. Instruction-level model
//               expands each instruction into its per-cycle control trace.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mainfsm_ext;
    import mainfsm_ext_pkg::*;

    logic clk;
    logic rst0;
    logic rst1;

    mainfsm_ext_if b0 ();
    mainfsm_ext_if b1 ();

    // dut0: defaults (MUL_EN=1, MUL_CYCLES=4, MEM_WAIT_EN=1)
    mainfsm_ext u_dut0 (
        .clk   (clk),
        .reset (rst0),
        .bus   (b0)
    );

    // dut1: multiply disabled, memory waits ignored
    mainfsm_ext #(
        .MUL_EN      (1'b0),
        .MUL_CYCLES  (1),
        .MEM_WAIT_EN (1'b0)
    ) u_dut1 (
        .clk   (clk),
        .reset (rst1),
        .bus   (b1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [19:0] q0[$];
    logic [19:0] q1[$];
    int          n_vec = 0;
    int          n_err = 0;
    int          cyc   = 0;

    logic [19:0] act0, act1;
    assign act0 = {b0.IRWrite, b0.AdrSrc, b0.ALUSrcA, b0.ALUSrcB, b0.ResultSrc,
                   b0.NextPC, b0.RegW, b0.LinkSel, b0.MemW, b0.MemReq, b0.Branch,
                   b0.ALUOp, b0.MulStart, b0.Undef, b0.StateOut};
    assign act1 = {b1.IRWrite, b1.AdrSrc, b1.ALUSrcA, b1.ALUSrcB, b1.ResultSrc,
                   b1.NextPC, b1.RegW, b1.LinkSel, b1.MemW, b1.MemReq, b1.Branch,
                   b1.ALUOp, b1.MulStart, b1.Undef, b1.StateOut};

    // All enables low, muxes at FETCH settings, state FETCH.
    localparam logic [19:0] RST_VEC = {3'b001, 2'b10, 2'b10, 9'b0, 4'd0};

    // Expected control word for one cycle spent in phase ph.
    function automatic logic [19:0] exp_of(input state_t ph, input logic rdy, input logic first);
        logic irw, adr, asa, npc, rw, ls, mw, mr, br, aop, ms, ud;
        logic [1:0] asb, rs;
        {irw, adr, asa, npc, rw, ls, mw, mr, br, aop, ms, ud} = '0;
        asb = 2'b00;
        rs  = 2'b00;
        case (ph)
            FETCH:    begin mr = 1; asa = 1; asb = 2'b10; rs = 2'b10; irw = rdy; npc = rdy; end
            DECODE:   begin asa = 1; asb = 2'b10; rs = 2'b10; end
            EXECUTER: begin aop = 1; asb = 2'b00; end
            EXECUTEI: begin aop = 1; asb = 2'b01; end
            ALUWB:    begin rw = 1; rs = 2'b00; end
            MEMADR:   begin asb = 2'b01; end
            MEMRD:    begin mr = 1; adr = 1; end
            MEMWB:    begin rw = 1; rs = 2'b01; end
            MEMWR:    begin mr = 1; mw = 1; adr = 1; end
            BRLINK:   begin asa = 1; asb = 2'b11; rs = 2'b10; rw = 1; ls = 1; end
            BRANCH:   begin br = 1; asa = 0; asb = 2'b01; rs = 2'b10; end
            MULEXEC:  begin ms = first; end
            MULWB:    begin rw = 1; rs = 2'b11; end
            UNDEF:    begin ud = 1; end
            default:  begin end
        endcase
        return {irw, adr, asa, asb, rs, npc, rw, ls, mw, mr, br, aop, ms, ud, 4'(ph)};
    endfunction

    // Monitor: compare the DUT against the head of its scoreboard each cycle.
    always @(negedge clk) begin
        cyc <= cyc + 1;
        if (q0.size() > 0) begin
            logic [19:0] e;
            e = q0.pop_front();
            n_vec++;
            if (act0 !== e) begin
                n_err++;
                $display("FAIL dut0_ctl cyc%0d: got st=%0d ctl=%h, want st=%0d ctl=%h",
                         cyc, act0[3:0], act0[19:4], e[3:0], e[19:4]);
            end
        end
        if (q1.size() > 0) begin
            logic [19:0] e;
            e = q1.pop_front();
            n_vec++;
            if (act1 !== e) begin
                n_err++;
                $display("FAIL dut1_ctl cyc%0d: got st=%0d ctl=%h, want st=%0d ctl=%h",
                         cyc, act1[3:0], act1[19:4], e[3:0], e[19:4]);
            end
        end
    end

    task automatic set_in(input int d, input logic [1:0] op, input logic [5:0] f,
                          input logic im, input logic lk);
        if (d == 0) begin
            b0.Op = op; b0.Funct = f; b0.IsMul = im; b0.Link = lk;
        end else begin
            b1.Op = op; b1.Funct = f; b1.IsMul = im; b1.Link = lk;
        end
    endtask

    // One clock cycle: drive MemReady, queue the expectation, advance.
    task automatic step(input int d, input logic mr, input logic [19:0] e);
        if (d == 0) begin
            b0.MemReady = mr;
            q0.push_back(e);
        end else begin
            b1.MemReady = mr;
            q1.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    // cls: 0 DP-reg, 1 DP-imm, 2 LDR, 3 STR, 4 B, 5 BL, 6 MUL, 7 Op=11
    task automatic run_instr(input int d, input int cls, input int fw_in, input int mw_in);
        logic mwe, mul_en;
        int   mc, fw, mw;
        logic [1:0] op;
        logic [5:0] f;
        logic im, lk;
        mwe    = (d == 0);
        mul_en = (d == 0);
        mc     = (d == 0) ? 4 : 1;
        fw     = mwe ? fw_in : 0;
        mw     = mwe ? mw_in : 0;
        f  = 6'($urandom);
        im = 1'($urandom);
        lk = 1'($urandom);
        case (cls)
            0: begin op = 2'b00; f[5] = 1'b0; im = 1'b0; end
            1: begin op = 2'b00; f[5] = 1'b1; im = 1'b0; end
            2: begin op = 2'b01; f[0] = 1'b1; end
            3: begin op = 2'b01; f[0] = 1'b0; end
            4: begin op = 2'b10; lk = 1'b0; end
            5: begin op = 2'b10; lk = 1'b1; end
            6: begin op = 2'b00; f[5:4] = 2'b00; im = 1'b1; end
            default: op = 2'b11;
        endcase
        set_in(d, op, f, im, lk);
        for (int i = 0; i < fw; i++) step(d, 1'b0, exp_of(FETCH, 1'b0, 1'b0));
        step(d, mwe ? 1'b1 : 1'($urandom), exp_of(FETCH, 1'b1, 1'b0));
        step(d, 1'($urandom), exp_of(DECODE, 1'b0, 1'b0));
        case (cls)
            0: begin
                step(d, 1'($urandom), exp_of(EXECUTER, 1'b0, 1'b0));
                step(d, 1'($urandom), exp_of(ALUWB, 1'b0, 1'b0));
            end
            1: begin
                step(d, 1'($urandom), exp_of(EXECUTEI, 1'b0, 1'b0));
                step(d, 1'($urandom), exp_of(ALUWB, 1'b0, 1'b0));
            end
            2: begin
                step(d, 1'($urandom), exp_of(MEMADR, 1'b0, 1'b0));
                for (int i = 0; i < mw; i++) step(d, 1'b0, exp_of(MEMRD, 1'b0, 1'b0));
                step(d, mwe ? 1'b1 : 1'($urandom), exp_of(MEMRD, 1'b0, 1'b0));
                step(d, 1'($urandom), exp_of(MEMWB, 1'b0, 1'b0));
            end
            3: begin
                step(d, 1'($urandom), exp_of(MEMADR, 1'b0, 1'b0));
                for (int i = 0; i < mw; i++) step(d, 1'b0, exp_of(MEMWR, 1'b0, 1'b0));
                step(d, mwe ? 1'b1 : 1'($urandom), exp_of(MEMWR, 1'b0, 1'b0));
            end
            4: step(d, 1'($urandom), exp_of(BRANCH, 1'b0, 1'b0));
            5: begin
                step(d, 1'($urandom), exp_of(BRLINK, 1'b0, 1'b0));
                step(d, 1'($urandom), exp_of(BRANCH, 1'b0, 1'b0));
            end
            6: begin
                if (mul_en) begin
                    for (int k = 0; k < mc; k++)
                        step(d, 1'($urandom), exp_of(MULEXEC, 1'b0, k == 0));
                    step(d, 1'($urandom), exp_of(MULWB, 1'b0, 1'b0));
                end else begin
                    step(d, 1'($urandom), exp_of(UNDEF, 1'b0, 1'b0));
                end
            end
            default: step(d, 1'($urandom), exp_of(UNDEF, 1'b0, 1'b0));
        endcase
    endtask

    // STR stalled in MEMWR, then reset pulled: access dropped, restart at FETCH.
    task automatic reset_mid_write();
        set_in(0, 2'b01, 6'b000000, 1'b0, 1'b0);
        step(0, 1'b1, exp_of(FETCH, 1'b1, 1'b0));
        step(0, 1'b0, exp_of(DECODE, 1'b0, 1'b0));
        step(0, 1'b0, exp_of(MEMADR, 1'b0, 1'b0));
        step(0, 1'b0, exp_of(MEMWR, 1'b0, 1'b0));
        b0.MemReady = 1'b0;
        rst0 = 1'b0;
        q0.push_back(RST_VEC);
        @(posedge clk);
        #1;
        b0.MemReady = 1'b1;
        q0.push_back(RST_VEC);
        @(posedge clk);
        #1;
        rst0 = 1'b1;
    endtask

    initial begin
        rst0 = 1'b0;
        rst1 = 1'b0;
        set_in(0, 2'b00, 6'b101000, 1'b0, 1'b0);
        set_in(1, 2'b00, 6'b101000, 1'b0, 1'b0);
        b0.MemReady = 1'b1;
        b1.MemReady = 1'b1;
        @(posedge clk);
        #1;
        q0.push_back(RST_VEC);
        q1.push_back(RST_VEC);
        @(posedge clk);
        #1;
        rst0 = 1'b1;

        // Directed: DP-imm, LDR with 3+3 waits, STR, BL, MUL, reset mid-write
        run_instr(0, 1, 0, 0);
        run_instr(0, 2, 3, 3);
        run_instr(0, 3, 0, 0);
        run_instr(0, 5, 0, 0);
        run_instr(0, 6, 0, 0);
        run_instr(0, 7, 0, 0);
        reset_mid_write();
        run_instr(0, 0, 1, 0);

        // Random instruction stream with random wait states
        for (int n = 0; n < 40; n++)
            run_instr(0, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3));

        // dut1: MUL goes to UNDEF, MemReady ignored
        q1.push_back(RST_VEC);
        @(posedge clk);
        #1;
        rst1 = 1'b1;
        run_instr(1, 6, 0, 0);
        for (int n = 0; n < 20; n++)
            run_instr(1, $urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, 3));

        @(posedge clk);
        #1;
        if (q0.size() != 0 || q1.size() != 0) begin
            n_err++;
            $display("FAIL drain: got %0d/%0d pending, want 0/0", q0.size(), q1.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mainfsm_ext.md
Name: mainfsm_ext

Overview:
Parametrised successor to the multi-cycle ARM control FSM. Sequences fetch, decode, execute, memory and writeback for data-processing, load/store and branch instructions. Adds four capabilities:
- variable-latency memory handshake (MemReq/MemReady wait states)
- multi-cycle multiply (MUL) with a configurable latency counter
- branch-with-link (BL)
- an explicit undefined-instruction state

It sits in the controller between the instruction decoder and the datapath/memory interface.

Parameters:
MUL_EN, 1, 1 enables the multiply path; 0 sends IsMul instructions to UNDEF.
MUL_CYCLES, 4, cycles spent in MULEXEC (legal range 1..16).
MEM_WAIT_EN, 1, 1 honours MemReady; 0 treats MemReady as constant 1.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (asserted when 0)
Op  in  2  Instr[27:26]
Funct  in  6  Instr[25:20]; [5]=I, [0]=L
IsMul  in  1  decoder flag: Op=00, Funct[5:4]=00, Instr[7:4]=1001
Link  in  1  Instr[24], valid when Op=10
MemReady  in  1  memory completes the current access this cycle
IRWrite  out  1  instruction register load enable
AdrSrc  out  1  0=PC, 1=ALU result (Result)
ALUSrcA  out  1  0=register A, 1=PC
ALUSrcB  out  2  00=reg B, 01=ExtImm, 10=const 4, 11=const 0
ResultSrc  out  2  00=ALUOut, 01=Data, 10=ALUResult, 11=MulResult
NextPC  out  1  PC write enable
RegW  out  1  register file write
LinkSel  out  1  forces register write address to R14
MemW  out  1  memory write
MemReq  out  1  memory access request
Branch  out  1  conditional PC write (branch)
ALUOp  out  1  1=decode ALU function from Funct
MulStart  out  1  one-cycle start pulse to the iterative multiplier
Undef  out  1  one-cycle pulse on an undefined instruction
StateOut  out  4  current state, for debug

Behaviour:
- State register is 4 bits, updated on posedge clk.
- reset=0 asynchronously forces FETCH and clears the MUL counter. While reset=0, IRWrite, NextPC, RegW, MemW, MemReq, Branch, MulStart and Undef are forced to 0. All other outputs take FETCH values.
- Outputs are combinational from state (Moore), except the MemReady qualification below. Any output not listed for a state is 0.
- FETCH: MemReq=1, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, IRWrite=NextPC=rdy. Holds until rdy. rdy = MemReady (or 1 when MEM_WAIT_EN=0).
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10. Next state, first match wins:
  - Op=00 & IsMul → MULEXEC if MUL_EN, else UNDEF
  - Op=00 → EXECUTEI if Funct[5], else EXECUTER
  - Op=01 → MEMADR
  - Op=10 → BRLINK if Link, else BRANCH
  - Op=11 → UNDEF
- EXECUTER: ALUOp=1, ALUSrcB=00 → ALUWB.
- EXECUTEI: ALUOp=1, ALUSrcB=01 → ALUWB.
- ALUWB: RegW=1, ResultSrc=00 → FETCH.
- MEMADR: ALUSrcB=01 → MEMRD if Funct[0], else MEMWR.
- MEMRD: MemReq=1, AdrSrc=1. Holds until rdy → MEMWB.
- MEMWB: RegW=1, ResultSrc=01 → FETCH.
- MEMWR: MemReq=1, MemW=1, AdrSrc=1. The write commits on the cycle MemReady=1; then → FETCH.
- BRLINK: ALUSrcA=1, ALUSrcB=11, ResultSrc=10, RegW=1, LinkSel=1 (writes PC+4 to R14) → BRANCH. Executes before BRANCH, so the PC is not yet modified.
- BRANCH: Branch=1, ALUSrcA=0, ALUSrcB=01, ResultSrc=10 → FETCH.
- MULEXEC:
  - Entry cycle: MulStart=1 and counter loads MUL_CYCLES-1.
  - While counter≠0, counter decrements each cycle and the FSM stays.
  - When counter=0 → MULWB.
  - MUL_CYCLES=1 gives exactly one cycle in MULEXEC.
- MULWB: RegW=1, ResultSrc=11 → FETCH.
- UNDEF: Undef=1 for one cycle → FETCH (instruction is skipped).
- Unused encodings → FETCH with all enables 0.
- Reset asserted during any wait state abandons the access with no write, and restarts the FSM at FETCH.
- Cycles per instruction with zero memory wait (FETCH included):
  - data-processing 4
  - LDR 5
  - STR 4
  - B 3
  - BL 4
  - MUL MUL_CYCLES+3
  - UNDEF 3

Decomposition:
- mainfsm_ext_pkg holds:
  - the state localparams (FETCH..UNDEF, 4 bits)
  - ALUSrcB codes (REG, IMM, FOUR, ZERO)
  - ResultSrc codes (ALUOUT, DATA, ALURES, MUL)
- One sub-module, mul_wait_counter: load, decrement and zero flag, width $clog2(MUL_CYCLES+1).

Test Plan:
1. Reset low, then high, with Op=00, Funct=6'b101000, MemReady=1 → state sequence FETCH, DECODE, EXECUTEI, ALUWB, FETCH. RegW=1 only in ALUWB. IRWrite and NextPC each assert for exactly one cycle.
2. LDR (Op=01, Funct[0]=1) with MemReady=0 for 3 cycles in both FETCH and MEMRD → FETCH held 4 cycles, IRWrite pulses once. MEMRD held 4 cycles. 5+6=11 cycles total.
3. STR (Funct[0]=0) with MemReady=1 → MemW=1, AdrSrc=1 for exactly one cycle, then FETCH.
4. BL (Op=10, Link=1) → DECODE, BRLINK (RegW=1, LinkSel=1, ALUSrcB=11), BRANCH (Branch=1), FETCH.
5. MUL with MUL_CYCLES=4 → MulStart high in the first MULEXEC cycle only. MULEXEC lasts 4 cycles, then MULWB with ResultSrc=11, RegW=1. With MUL_EN=0 the same instruction → UNDEF, Undef pulses once.
6. Reset driven low mid-MEMWR while MemReady=0 → immediately StateOut=0, MemW=0, MemReq=0. After release, the FSM resumes at FETCH.
